i2c_target_writer: RTL

I2C_TARGET_WRITER -- requirements
Module: i2c_target_writer

---
 rtl/i2c_target_writer.sv | 122 ++++++++++++
 1 files changed

// File: rtl/i2c_target_writer.sv
// Write-only I2C target: START, {DEV_ID,W}, reg addr hi, reg addr lo, data bytes..., STOP.
// Each data byte is presented on wr_valid/wr_addr/wr_data; the register address auto-increments.
module i2c_target_writer #(
  parameter logic [6:0] DEV_ID      = 7'h35,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clock,
  input  logic        reset,
  inout  wire         sda_io,
  inout  wire         scl_io,
  output logic        wr_valid,
  output logic [15:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy
);

  typedef enum logic [3:0] {
    IDLE, DEV, ACK_DEV, REG_HI, ACK_HI, REG_LO, ACK_LO, DATA, ACK_DATA, IGNORE
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] scl_sync, sda_sync;
  logic                   scl_prev, sda_prev;
  logic                   sda_oe, ack_hold;
  logic [7:0]             shreg;
  logic [3:0]             bit_cnt;
  logic [15:0]            addr;

  // Open drain: SDA only ever pulled low, SCL never driven (no clock stretching).
  assign sda_io = sda_oe ? 1'b0 : 1'bz;
  assign scl_io = 1'bz;

  // Synchronizers reset to the idle bus level so leaving reset looks like a quiet bus.
  always_ff @(posedge clock) begin
    if (reset) begin
      scl_sync <= '1;
      sda_sync <= '1;
      scl_prev <= 1'b1;
      sda_prev <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[SYNC_STAGES-2:0], scl_io};
      sda_sync <= {sda_sync[SYNC_STAGES-2:0], sda_io};
      scl_prev <= scl_sync[SYNC_STAGES-1];
      sda_prev <= sda_sync[SYNC_STAGES-1];
    end
  end

  logic       scl_s, sda_s, start_det, stop_det, scl_rise, scl_fall, byte_done;
  logic [7:0] nxt_byte;

  assign scl_s     = scl_sync[SYNC_STAGES-1];
  assign sda_s     = sda_sync[SYNC_STAGES-1];
  assign start_det = scl_s & sda_prev & ~sda_s;
  assign stop_det  = scl_s & ~sda_prev & sda_s;
  assign scl_rise  = scl_s & ~scl_prev;
  assign scl_fall  = ~scl_s & scl_prev;
  assign nxt_byte  = {shreg[6:0], sda_s};
  assign byte_done = scl_rise && (bit_cnt == 4'd7);
  assign busy      = (state != IDLE);

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      sda_oe   <= 1'b0;
      ack_hold <= 1'b0;
      shreg    <= 8'h00;
      bit_cnt  <= 4'd0;
      addr     <= 16'h0000;
      wr_valid <= 1'b0;
      wr_addr  <= 16'h0000;
      wr_data  <= 8'h00;
    end else begin
      wr_valid <= 1'b0;
      // Bus conditions pre-empt any bit activity seen in the same cycle.
      if (start_det || stop_det) begin
        state    <= start_det ? DEV : IDLE;
        sda_oe   <= 1'b0;
        ack_hold <= 1'b0;
        bit_cnt  <= 4'd0;
      end else begin
        case (state)
          DEV, REG_HI, REG_LO, DATA: begin
            if (scl_rise) begin
              shreg   <= nxt_byte;
              bit_cnt <= byte_done ? 4'd0 : bit_cnt + 4'd1;
            end
            if (byte_done) begin
              case (state)
                DEV:     state <= (nxt_byte == {DEV_ID, 1'b0}) ? ACK_DEV : IGNORE;
                REG_HI:  begin addr[15:8] <= nxt_byte; state <= ACK_HI; end
                REG_LO:  begin addr[7:0]  <= nxt_byte; state <= ACK_LO; end
                default: state <= ACK_DATA;
              endcase
            end
          end
          ACK_DEV, ACK_HI, ACK_LO, ACK_DATA: begin
            if (scl_fall && !ack_hold) begin
              sda_oe   <= 1'b1;
              ack_hold <= 1'b1;
              if (state == ACK_DATA) begin
                wr_valid <= 1'b1;
                wr_addr  <= addr;
                wr_data  <= shreg;
                addr     <= addr + 16'd1;
              end
            end else if (scl_fall) begin
              sda_oe   <= 1'b0;
              ack_hold <= 1'b0;
              case (state)
                ACK_DEV: state <= REG_HI;
                ACK_HI:  state <= REG_LO;
                default: state <= DATA;
              endcase
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
